// File: rtl/satadd_sched_if.sv
// Request/response bundle for satadd_sched: two packed 12-bit requesters in,
// one held result out. master = requester/consumer side, slave = scheduler.
interface satadd_sched_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [23:0] req_x;
    logic [23:0] req_y;
    logic [3:0]  req_mode;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [11:0] rsp_sum;
    logic        rsp_sat;

    modport master (
        output req_valid, req_x, req_y, req_mode, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_sat
    );

    modport slave (
        input  req_valid, req_x, req_y, req_mode, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_sat
    );
endinterface

// File: rtl/satadd_sched.sv
// Two-requester round-robin scheduler feeding one wrap/signed/unsigned saturating adder.
// Optional per-requester saturation counters are enabled by defining SATADD_SCHED_CNT_EN.
module satadd_sched #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    satadd_sched_if.slave    bus,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] sat_cnt_a,
    output logic [CNT_W-1:0] sat_cnt_b
);
    localparam int DATA_W = 12;
    localparam int MSB    = DATA_W - 1;
    localparam logic signed [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic {IDLE, RESP} state_t;

    // Returns {sat, sum}; mode 1x wraps, 01 clamps signed, 00 clamps unsigned.
    function automatic logic [DATA_W:0] sat_add(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y,
                                                input logic [1:0]        mode);
        logic [DATA_W:0] r;
        logic            ovf;
        r   = {1'b0, x} + {1'b0, y};
        ovf = (x[MSB] == y[MSB]) && (r[MSB] != x[MSB]);
        if (mode[1])
            return {1'b0, r[DATA_W-1:0]};
        else if (mode[0])
            return ovf ? {1'b1, (x[MSB] ? SMIN : SMAX)} : {1'b0, r[DATA_W-1:0]};
        else
            return r[DATA_W] ? {1'b1, {DATA_W{1'b1}}} : {1'b0, r[DATA_W-1:0]};
    endfunction

    state_t            state;
    logic              last_b;
    logic [1:0]        grant;
    logic              xfer;
    logic              gid;
    logic [DATA_W-1:0] x_p0, y_p0;
    logic [1:0]        mode_p0;
    logic [DATA_W:0]   res_p0;
    logic              vld_p1;
    logic [DATA_W-1:0] sum_p1;
    logic              sat_p1;
    logic              id_p1;

    // Stage p0: grant and operand select
    always_comb begin
        grant = 2'b00;
        if (state == IDLE) begin
            case (bus.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_b ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign xfer          = |grant;
    assign gid           = grant[1];
    assign bus.req_ready = grant;

    always_comb begin
        x_p0    = gid ? bus.req_x[2*DATA_W-1:DATA_W] : bus.req_x[DATA_W-1:0];
        y_p0    = gid ? bus.req_y[2*DATA_W-1:DATA_W] : bus.req_y[DATA_W-1:0];
        mode_p0 = gid ? bus.req_mode[3:2] : bus.req_mode[1:0];
        res_p0  = sat_add(x_p0, y_p0, mode_p0);
    end

    // Stage p1: held result and FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            vld_p1 <= 1'b0;
            sum_p1 <= '0;
            sat_p1 <= 1'b0;
            id_p1  <= 1'b0;
            last_b <= 1'b1;
        end else if (state == IDLE) begin
            if (xfer) begin
                state  <= RESP;
                vld_p1 <= 1'b1;
                sum_p1 <= res_p0[DATA_W-1:0];
                sat_p1 <= res_p0[DATA_W];
                id_p1  <= gid;
                last_b <= gid;
            end
        end else if (bus.rsp_ready) begin
            state  <= IDLE;
            vld_p1 <= 1'b0;
        end
    end

    assign bus.rsp_valid = vld_p1;
    assign bus.rsp_sum   = sum_p1;
    assign bus.rsp_sat   = sat_p1;
    assign bus.rsp_id    = id_p1;

`ifdef SATADD_SCHED_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Counters stick at all-ones; a clear in the same cycle beats an increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt_a <= '0;
            sat_cnt_b <= '0;
        end else if (clr_cnt) begin
            sat_cnt_a <= '0;
            sat_cnt_b <= '0;
        end else if (xfer && res_p0[DATA_W]) begin
            if (!gid && sat_cnt_a != CNT_MAX) sat_cnt_a <= sat_cnt_a + CNT_W'(1);
            if (gid && sat_cnt_b != CNT_MAX)  sat_cnt_b <= sat_cnt_b + CNT_W'(1);
        end
    end
`else
    logic unused_clr;
    assign unused_clr = clr_cnt;
    assign sat_cnt_a  = '0;
    assign sat_cnt_b  = '0;
`endif
endmodule

// File: tb/tb_satadd_sched.sv
// Self-checking bench for satadd_sched: arithmetic/queue-level model checked every cycle
// plus directed vectors with literal expectations.
module tb_satadd_sched;
    localparam int CNT_W = 2;
`ifdef SATADD_SCHED_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic clr_cnt;
    logic [CNT_W-1:0] sat_cnt_a, sat_cnt_b;

    satadd_sched_if bus ();

    satadd_sched #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .clr_cnt   (clr_cnt),
        .sat_cnt_a (sat_cnt_a),
        .sat_cnt_b (sat_cnt_b)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Arithmetic reference: integer sums clamped to the representable range.
    function automatic void calc(input int x, input int y, input int mode,
                                 output int s, output int sat);
        int sx, sy, t;
        if (mode >= 2) begin
            s = (x + y) % 4096; sat = 0;
        end else if (mode == 1) begin
            sx = (x >= 2048) ? x - 4096 : x;
            sy = (y >= 2048) ? y - 4096 : y;
            t  = sx + sy;
            if (t > 2047)       begin s = 12'h7FF; sat = 1; end
            else if (t < -2048) begin s = 12'h800; sat = 1; end
            else                begin s = (t + 4096) % 4096; sat = 0; end
        end else begin
            t = x + y;
            if (t > 4095) begin s = 12'hFFF; sat = 1; end
            else          begin s = t; sat = 0; end
        end
    endfunction

    // Model state
    int m_busy, m_last, m_sum, m_sat, m_id, m_cnt[2];

    function automatic int pick(input logic [1:0] v);
        if (v == 2'b11) return (m_last == 1) ? 0 : 1;
        if (v[0]) return 0;
        if (v[1]) return 1;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        int w, s, st;
        if (rst) begin
            m_busy = 0; m_last = 1; m_sum = 0; m_sat = 0; m_id = 0;
            m_cnt[0] = 0; m_cnt[1] = 0;
        end else begin
            w = m_busy ? -1 : pick(bus.req_valid);
            st = 0;
            if (m_busy && bus.rsp_ready) m_busy = 0;
            else if (w >= 0) begin
                calc((bus.req_x >> (12 * w)) & 12'hFFF, (bus.req_y >> (12 * w)) & 12'hFFF,
                     (bus.req_mode >> (2 * w)) & 2'b11, s, st);
                m_busy = 1; m_last = w; m_sum = s; m_sat = st; m_id = w;
            end
            if (CNT_ON == 1) begin
                if (clr_cnt) begin m_cnt[0] = 0; m_cnt[1] = 0; end
                else if (w >= 0 && st == 1 && m_cnt[w] < (1 << CNT_W) - 1) m_cnt[w] = m_cnt[w] + 1;
            end
        end
    end

    always @(negedge clk) begin
        int w;
        logic [1:0] er;
        er = 2'b00;
        w = m_busy ? -1 : pick(bus.req_valid);
        if (w >= 0) er = 2'b01 << w;
        chk("req_ready", bus.req_ready, er);
        chk("rsp_valid", bus.rsp_valid, m_busy);
        chk("rsp_sum",   bus.rsp_sum, m_sum);
        chk("rsp_sat",   bus.rsp_sat, m_sat);
        chk("rsp_id",    bus.rsp_id, m_id);
        chk("sat_cnt_a", sat_cnt_a, m_cnt[0]);
        chk("sat_cnt_b", sat_cnt_b, m_cnt[1]);
    end

    // One isolated operation starting from IDLE, with literal expectations.
    task automatic op(input string nm, input logic [1:0] v,
                      input logic [11:0] xa, input logic [11:0] ya,
                      input logic [11:0] xb, input logic [11:0] yb,
                      input logic [1:0] ma, input logic [1:0] mb, input logic clr,
                      input logic [11:0] es, input logic esat, input logic eid);
        @(posedge clk); #1;
        bus.req_valid = v; bus.req_x = {xb, xa}; bus.req_y = {yb, ya};
        bus.req_mode = {mb, ma}; clr_cnt = clr; bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 2'b00; clr_cnt = 1'b0;
        #1;
        chk({nm, ".valid"}, bus.rsp_valid, 1'b1);
        chk({nm, ".sum"},   bus.rsp_sum, es);
        chk({nm, ".sat"},   bus.rsp_sat, esat);
        chk({nm, ".id"},    bus.rsp_id, eid);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic wait_rsp(input string nm);
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.rsp_valid) begin
            checks++; failures++;
            $display("FAIL %s timeout waiting for rsp_valid actual=0 expected=1", nm);
        end
    endtask

    initial begin
        logic [11:0] held_sum;
        logic        held_id;
        logic [11:0] sums[4];
        logic        ids[4];

        rst = 1'b1; clr_cnt = 1'b0;
        bus.req_valid = 2'b00; bus.req_x = '0; bus.req_y = '0;
        bus.req_mode = '0; bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset.valid", bus.rsp_valid, 1'b0);
        chk("reset.sum",   bus.rsp_sum, 12'h000);
        chk("reset.sat",   bus.rsp_sat, 1'b0);
        chk("reset.id",    bus.rsp_id, 1'b0);
        chk("reset.cnt_a", sat_cnt_a, 2'd0);

        op("a_spos",  2'b01, 12'h7F0, 12'h020, 12'h000, 12'h000, 2'b01, 2'b00, 1'b0, 12'h7FF, 1'b1, 1'b0);
        op("b_usat",  2'b10, 12'h000, 12'h000, 12'hF00, 12'h200, 2'b00, 2'b00, 1'b0, 12'hFFF, 1'b1, 1'b1);
        op("b_wrap",  2'b10, 12'h000, 12'h000, 12'hF00, 12'h200, 2'b00, 2'b10, 1'b0, 12'h100, 1'b0, 1'b1);
        op("a_sneg",  2'b01, 12'h800, 12'hFFF, 12'h000, 12'h000, 2'b01, 2'b00, 1'b0, 12'h800, 1'b1, 1'b0);
        op("a_uplain",2'b01, 12'h001, 12'h002, 12'h000, 12'h000, 2'b00, 2'b00, 1'b0, 12'h003, 1'b0, 1'b0);
        op("a_snoovf",2'b01, 12'h7FF, 12'h801, 12'h000, 12'h000, 2'b01, 2'b00, 1'b0, 12'h000, 1'b0, 1'b0);
        op("a_usat2", 2'b01, 12'hFFF, 12'h001, 12'h000, 12'h000, 2'b00, 2'b00, 1'b0, 12'hFFF, 1'b1, 1'b0);
        op("a_spos2", 2'b01, 12'h400, 12'h400, 12'h000, 12'h000, 2'b01, 2'b00, 1'b0, 12'h7FF, 1'b1, 1'b0);
        chk("cnt_a_stick", sat_cnt_a, (CNT_ON == 1) ? 2'd3 : 2'd0);
        chk("cnt_b",       sat_cnt_b, (CNT_ON == 1) ? 2'd1 : 2'd0);
        op("a_clr",   2'b01, 12'h7F0, 12'h020, 12'h000, 12'h000, 2'b01, 2'b00, 1'b1, 12'h7FF, 1'b1, 1'b0);
        chk("cnt_a_clr", sat_cnt_a, 2'd0);

        // Continuous contention after reset, each response back-pressured 3 cycles
        @(posedge clk); #1 rst = 1'b1;
        #3 rst = 1'b0;
        @(posedge clk); #1;
        bus.req_x = {12'h200, 12'h100}; bus.req_y = {12'h002, 12'h001};
        bus.req_mode = {2'b10, 2'b10}; bus.req_valid = 2'b11; bus.rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_rsp("rr");
            ids[k] = bus.rsp_id; sums[k] = bus.rsp_sum;
            held_id = bus.rsp_id; held_sum = bus.rsp_sum;
            repeat (3) begin
                @(posedge clk); #1;
                chk("hold.valid", bus.rsp_valid, 1'b1);
                chk("hold.sum",   bus.rsp_sum, held_sum);
                chk("hold.id",    bus.rsp_id, held_id);
            end
            bus.rsp_ready = 1'b1;
            @(posedge clk); #1;
            bus.rsp_ready = 1'b0;
        end
        chk("rr.id0", ids[0], 1'b0); chk("rr.sum0", sums[0], 12'h101);
        chk("rr.id1", ids[1], 1'b1); chk("rr.sum1", sums[1], 12'h202);
        chk("rr.id2", ids[2], 1'b0); chk("rr.sum2", sums[2], 12'h101);
        chk("rr.id3", ids[3], 1'b1); chk("rr.sum3", sums[3], 12'h202);

        // Reset while holding a result (A was granted last, so only reset makes A win next)
        wait_rsp("pre_rst");
        chk("pre_rst.id", bus.rsp_id, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rst_resp.valid", bus.rsp_valid, 1'b0);
        chk("rst_resp.sum",   bus.rsp_sum, 12'h000);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        wait_rsp("post_rst");
        chk("post_rst.id",  bus.rsp_id, 1'b0);
        chk("post_rst.sum", bus.rsp_sum, 12'h101);
        bus.req_valid = 2'b00; bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
